// File: rtl/axum_uart_bus_host_if.sv
// Byte-stream (UART RX/TX FIFO) and peripheral-bus signals of the UART bus host.
// The master modport is the host's view; the slave modport is the FIFO/responder side.
interface axum_uart_bus_host_if;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  modport master (
    input  rx_valid_i, rx_data_i, tx_ready_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    output rx_ready_o, tx_valid_o, tx_data_o,
    output bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o
  );

  modport slave (
    output rx_valid_i, rx_data_i, tx_ready_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    input  rx_ready_o, tx_valid_o, tx_data_o,
    input  bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o
  );
endinterface

// File: rtl/axum_uart_bus_host.sv
// UART-to-bus bridge: parses 'R'/'W' byte frames from the RX stream, performs one
// bus access and answers on the TX stream with a status byte (plus read data).
//
// Handshakes: a byte moves on rx (or tx) in a cycle where valid and ready are both
// high at the clock edge; valid never waits on ready, and the tx byte is held
// stable while tx_valid_o is high and not yet accepted.
module axum_uart_bus_host #(
  parameter  int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  axum_uart_bus_host_if.master   link,
  output logic                   busy_o,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS_REQ,
    S_BUS_WAIT,
    S_RESP_STATUS,
    S_RESP_DATA,
    S_RESP_BAD
  } state_e;

  localparam logic [7:0]      CMD_READ   = 8'h52;
  localparam logic [7:0]      CMD_WRITE  = 8'h57;
  localparam logic [1:0]      ST_OK      = 2'd0;
  localparam logic [1:0]      ST_ERR     = 2'd1;
  localparam logic [1:0]      ST_TIMEOUT = 2'd2;
  localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      byte_cnt_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic [1:0]      status_q;
  logic [TO_W-1:0] to_cnt_q;

  logic            rx_ready;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            bus_req;
  logic            rx_fire;
  logic            tx_fire;
  logic            last_byte;
  logic            to_hit;
  logic            in_bus;

  assign rx_fire   = link.rx_valid_i & rx_ready;
  assign tx_fire   = tx_valid & link.tx_ready_i;
  assign last_byte = (byte_cnt_q == 2'd3);
  // The final counted cycle is the one where the access is abandoned.
  assign to_hit    = (to_cnt_q >= TO_LAST);
  assign in_bus    = (state_q == S_BUS_REQ) || (state_q == S_BUS_WAIT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    bus_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (link.rx_valid_i) begin
          if ((link.rx_data_i == CMD_READ) || (link.rx_data_i == CMD_WRITE)) state_d = S_ADDR;
          else                                                               state_d = S_RESP_BAD;
        end
      end
      S_ADDR: begin
        rx_ready = 1'b1;
        if (link.rx_valid_i && last_byte) state_d = we_q ? S_DATA : S_BUS_REQ;
      end
      S_DATA: begin
        rx_ready = 1'b1;
        if (link.rx_valid_i && last_byte) state_d = S_BUS_REQ;
      end
      S_BUS_REQ: begin
        bus_req = 1'b1;
        if (link.bus_gnt_i) state_d = S_BUS_WAIT;
        else if (to_hit)    state_d = S_RESP_STATUS;
      end
      S_BUS_WAIT: begin
        // A response in the limit cycle still counts as a response.
        if (link.bus_rvalid_i || to_hit) state_d = S_RESP_STATUS;
      end
      S_RESP_STATUS: begin
        tx_valid = 1'b1;
        tx_data  = {6'd0, status_q};
        if (link.tx_ready_i) state_d = we_q ? S_IDLE : S_RESP_DATA;
      end
      S_RESP_DATA: begin
        tx_valid = 1'b1;
        tx_data  = rdata_q[7:0];
        if (link.tx_ready_i && last_byte) state_d = S_IDLE;
      end
      S_RESP_BAD: begin
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        if (link.tx_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      byte_cnt_q <= 2'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      status_q   <= ST_OK;
      to_cnt_q   <= '0;
    end else begin
      if (!in_bus) to_cnt_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (rx_fire) begin
            we_q       <= (link.rx_data_i == CMD_WRITE);
            byte_cnt_q <= 2'd0;
          end
        end
        S_ADDR: begin
          // Little-endian bytes shift in from the top.
          if (rx_fire) begin
            addr_q     <= {link.rx_data_i, addr_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            wdata_q    <= {link.rx_data_i, wdata_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        S_BUS_REQ, S_BUS_WAIT: begin
          if (to_cnt_q < TO_LIMIT) to_cnt_q <= to_cnt_q + TO_W'(1);
          if ((state_q == S_BUS_WAIT) && link.bus_rvalid_i) begin
            status_q <= link.bus_err_i ? ST_ERR : ST_OK;
            rdata_q  <= (!we_q && !link.bus_err_i) ? link.bus_rdata_i : 32'd0;
          end else if (state_d == S_RESP_STATUS) begin
            status_q <= ST_TIMEOUT;
            rdata_q  <= 32'd0;
          end
        end
        S_RESP_STATUS: begin
          byte_cnt_q <= 2'd0;
        end
        S_RESP_DATA: begin
          if (tx_fire) begin
            rdata_q    <= {8'h00, rdata_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign link.rx_ready_o  = rx_ready;
  assign link.tx_valid_o  = tx_valid;
  assign link.tx_data_o   = tx_data;
  assign link.bus_req_o   = bus_req;
  assign link.bus_addr_o  = addr_q;
  assign link.bus_we_o    = we_q;
  // Full-word accesses only; enables are shown while a request is presented.
  assign link.bus_be_o    = {4{bus_req}};
  assign link.bus_wdata_o = wdata_q;

  assign busy_o  = (state_q != S_IDLE);
  assign state_o = state_q;

endmodule
